// File: rtl/emergency_dispatcher.sv
// Sequences classifier flags into an authority message handshake (timeout + bounded retry)
// and drives the siren pattern / evacuation light. Optional clear message: DISPATCH_CLEAR_MSG_EN.
module emergency_dispatcher #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRY      = 3,
    parameter int TONE_DIV       = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       AuthorityContacted,
    input  logic       isFire,
    input  logic       isStorm,
    input  logic       lockdownNeeded,
    input  logic       isMedicalEmergency,
    input  logic       confirmedEmergency,
    input  logic       warnStudents,
    input  logic       needEvacuation,
    input  logic       allClear,
    input  logic       msgAck,
    output logic       msgValid,
    output logic [2:0] msgCode,
    output logic       linkFault,
    output logic       siren,
    output logic       evacLight,
    output logic       busy
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PW = $clog2(8 * TONE_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [PW-1:0] PHASE_LAST = PW'(8 * TONE_DIV - 1);
    localparam logic [2:0]    CODE_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        IDLE, SEND, GAP, DONE, FAULT
`ifdef DISPATCH_CLEAR_MSG_EN
        , CLR_SEND
`endif
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [PW-1:0] phase;
    logic [2:0]    liveCode;
    logic          toneHigh;

    always_comb begin
        liveCode = 3'd0;
        if (isFire)                  liveCode = 3'd1;
        else if (isStorm)            liveCode = 3'd2;
        else if (lockdownNeeded)     liveCode = 3'd3;
        else if (isMedicalEmergency) liveCode = 3'd4;
        else if (confirmedEmergency) liveCode = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            msgValid  <= 1'b0;
            msgCode   <= 3'd0;
            linkFault <= 1'b0;
            busy      <= 1'b0;
            timer     <= '0;
            retry     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (AuthorityContacted && liveCode != 3'd0) begin
                        state    <= SEND;
                        msgCode  <= liveCode;
                        msgValid <= 1'b1;
                        busy     <= 1'b1;
                        timer    <= '0;
                        retry    <= '0;
                    end
                end
`ifdef DISPATCH_CLEAR_MSG_EN
                SEND, CLR_SEND: begin
`else
                SEND: begin
`endif
                    // ack on the timeout edge takes precedence over the timeout
                    if (msgAck && msgValid) begin
                        msgValid <= 1'b0;
                        timer    <= '0;
                        if (msgCode == CODE_CLEAR) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DONE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        msgValid <= 1'b0;
                        timer    <= '0;
                        if (retry < RETRY_MAX) begin
                            state <= GAP;
                            retry <= retry + 1'b1;
                        end else begin
                            state     <= FAULT;
                            linkFault <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    msgValid <= 1'b1;
                    timer    <= '0;
`ifdef DISPATCH_CLEAR_MSG_EN
                    state    <= (msgCode == CODE_CLEAR) ? CLR_SEND : SEND;
`else
                    state    <= SEND;
`endif
                end
                DONE: begin
                    if (AuthorityContacted && liveCode != 3'd0 && liveCode != msgCode) begin
                        state    <= SEND;
                        msgCode  <= liveCode;
                        msgValid <= 1'b1;
                        timer    <= '0;
                        retry    <= '0;
                    end else if (allClear) begin
`ifdef DISPATCH_CLEAR_MSG_EN
                        state    <= CLR_SEND;
                        msgCode  <= CODE_CLEAR;
                        msgValid <= 1'b1;
                        timer    <= '0;
                        retry    <= '0;
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
`endif
                    end else if (!AuthorityContacted) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FAULT: begin
                    if (!AuthorityContacted || allClear) begin
                        state     <= IDLE;
                        linkFault <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    msgValid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Phase spans one 8*TONE_DIV period; fire alternates every TONE_DIV within it.
    always_comb begin
        toneHigh = 1'b0;
        case (liveCode)
            3'd0: toneHigh = 1'b0;
            3'd1: toneHigh = (phase < PW'(TONE_DIV))
                          || (phase >= PW'(2 * TONE_DIV) && phase < PW'(3 * TONE_DIV))
                          || (phase >= PW'(4 * TONE_DIV) && phase < PW'(5 * TONE_DIV))
                          || (phase >= PW'(6 * TONE_DIV) && phase < PW'(7 * TONE_DIV));
            3'd2: toneHigh = phase < PW'(4 * TONE_DIV);
            default: toneHigh = phase < PW'(TONE_DIV);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !warnStudents) begin
            phase <= '0;
            siren <= 1'b0;
        end else begin
            siren <= toneHigh;
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) evacLight <= 1'b0;
        else        evacLight <= needEvacuation && !allClear;
    end
endmodule

// File: tb/tb_emergency_dispatcher.sv
// Randomized self-checking bench for emergency_dispatcher against a behavioural model
// (priority scan, arithmetic attempt windows and siren waveforms).
module tb_emergency_dispatcher;
    localparam int TO = 1000;
    localparam int MR = 3;
    localparam int TD = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic AuthorityContacted = 1'b0;
    logic isFire = 1'b0, isStorm = 1'b0, lockdownNeeded = 1'b0;
    logic isMedicalEmergency = 1'b0, confirmedEmergency = 1'b0;
    logic warnStudents = 1'b0, needEvacuation = 1'b0, allClear = 1'b0;
    logic msgAck = 1'b0;
    logic msgValid, linkFault, siren, evacLight, busy;
    logic [2:0] msgCode;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    emergency_dispatcher #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .TONE_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .AuthorityContacted(AuthorityContacted),
        .isFire(isFire), .isStorm(isStorm), .lockdownNeeded(lockdownNeeded),
        .isMedicalEmergency(isMedicalEmergency), .confirmedEmergency(confirmedEmergency),
        .warnStudents(warnStudents), .needEvacuation(needEvacuation), .allClear(allClear),
        .msgAck(msgAck), .msgValid(msgValid), .msgCode(msgCode), .linkFault(linkFault),
        .siren(siren), .evacLight(evacLight), .busy(busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sets flag c (1..5) plus random lower-priority flags; c=0 clears all.
    task automatic setCode(input int c);
        logic [5:1] f;
        for (int i = 1; i <= 5; i++) f[i] = (i > c && c != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c != 0) f[c] = 1'b1;
        isFire = f[1]; isStorm = f[2]; lockdownNeeded = f[3];
        isMedicalEmergency = f[4]; confirmedEmergency = f[5];
    endtask

    function automatic int modelCode();
        logic [5:1] f;
        f = {confirmedEmergency, isMedicalEmergency, lockdownNeeded, isStorm, isFire};
        for (int i = 1; i <= 5; i++) if (f[i]) return i;
        return 0;
    endfunction

    function automatic logic sirenModel(input int code, input int k);
        int p;
        p = k % (8 * TD);
        if (code == 1) return ((k / TD) % 2) == 0;
        if (code == 2) return p < 4 * TD;
        return p < TD;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++; if (msgValid !== 1'b0) begin bad++; $display("FAIL reset_msgValid got=%b want=0", msgValid); end
        total++; if (msgCode !== 3'd0) begin bad++; $display("FAIL reset_msgCode got=%0d want=0", msgCode); end
        total++; if (linkFault !== 1'b0) begin bad++; $display("FAIL reset_linkFault got=%b want=0", linkFault); end
        total++; if (siren !== 1'b0) begin bad++; $display("FAIL reset_siren got=%b want=0", siren); end
        total++; if (evacLight !== 1'b0) begin bad++; $display("FAIL reset_evacLight got=%b want=0", evacLight); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fire_ack();
        int n;
        setCode(1);
        AuthorityContacted = 1'b1;
        tick();
        total++; if (msgValid !== 1'b1) begin bad++; $display("FAIL fire_valid got=%b want=1", msgValid); end
        total++; if (msgCode !== 3'd1) begin bad++; $display("FAIL fire_code got=%0d want=1", msgCode); end
        n = 5;
        for (int k = 1; k < n; k++) begin
            tick();
            total++; if (msgValid !== 1'b1) begin bad++; $display("FAIL fire_hold k=%0d got=%b want=1", k, msgValid); end
        end
        msgAck = 1'b1;
        tick();
        msgAck = 1'b0;
        total++; if (msgValid !== 1'b0) begin bad++; $display("FAIL fire_ackdrop got=%b want=0", msgValid); end
        for (int k = 0; k < 20; k++) begin
            tick();
            total++; if (msgValid !== 1'b0 || busy !== 1'b1)
                begin bad++; $display("FAIL fire_done k=%0d valid=%b busy=%b want valid=0 busy=1", k, msgValid, busy); end
        end
    endtask

    task automatic test_code_change();
        int c, n;
        for (int step = 0; step < 2; step++) begin
            c = (step == 0) ? 2 : 3;
            setCode(c);
            tick();
            total++; if (msgValid !== 1'b1 || msgCode !== 3'(modelCode()))
                begin bad++; $display("FAIL change_send valid=%b code=%0d want valid=1 code=%0d", msgValid, msgCode, modelCode()); end
            n = $urandom_range(1, 12);
            for (int k = 1; k < n; k++) begin
                tick();
                total++; if (msgValid !== 1'b1 || msgCode !== 3'(c))
                    begin bad++; $display("FAIL change_hold valid=%b code=%0d want 1/%0d", msgValid, msgCode, c); end
            end
            msgAck = 1'b1;
            tick();
            msgAck = 1'b0;
            total++; if (msgValid !== 1'b0 || busy !== 1'b1)
                begin bad++; $display("FAIL change_ack valid=%b busy=%b want 0/1", msgValid, busy); end
        end
    endtask

    task automatic test_no_ack();
        int c;
        logic expV, expF;
        AuthorityContacted = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL noack_idle busy=%b want=0", busy); end
        c = $urandom_range(1, 5);
        setCode(c);
        AuthorityContacted = 1'b1;
        for (int cyc = 1; cyc <= 4010; cyc++) begin
            tick();
            expV = ((cyc - 1) % (TO + 1)) < TO && cyc <= (MR + 1) * TO + MR;
            expF = cyc >= (MR + 1) * TO + MR + 1;
            total++; if (msgValid !== expV || linkFault !== expF)
                begin bad++; $display("FAIL noack cyc=%0d valid=%b fault=%b want %b/%b", cyc, msgValid, linkFault, expV, expF); end
            if (expV) begin
                total++; if (msgCode !== 3'(c)) begin bad++; $display("FAIL noack_code cyc=%0d got=%0d want=%0d", cyc, msgCode, c); end
            end
            // acks offered while msgValid is low must be ignored
            msgAck = (!expV) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        msgAck = 1'b0;
        AuthorityContacted = 1'b0;
        tick();
        total++; if (linkFault !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL noack_exit fault=%b busy=%b want 0/0", linkFault, busy); end
    endtask

    task automatic test_clear();
        int n;
        setCode($urandom_range(1, 5));
        AuthorityContacted = 1'b1;
        tick();
        msgAck = 1'b1;
        tick();
        msgAck = 1'b0;
        total++; if (msgValid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL clear_setup valid=%b busy=%b want 0/1", msgValid, busy); end
        setCode(0);
        allClear = 1'b1;
        tick();
`ifdef DISPATCH_CLEAR_MSG_EN
        total++; if (msgValid !== 1'b1 || msgCode !== 3'd7)
            begin bad++; $display("FAIL clear_send valid=%b code=%0d want 1/7", msgValid, msgCode); end
        n = $urandom_range(1, 10);
        for (int k = 1; k < n; k++) tick();
        msgAck = 1'b1;
        tick();
        msgAck = 1'b0;
        total++; if (msgValid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL clear_done valid=%b busy=%b want 0/0", msgValid, busy); end
`else
        n = 0;
        total++; if (msgValid !== 1'b0 || busy !== 1'b0 || msgCode == 3'd7)
            begin bad++; $display("FAIL clear_silent valid=%b busy=%b code=%0d want 0/0/not7", msgValid, busy, msgCode); end
`endif
        allClear = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || msgValid !== 1'b0)
            begin bad++; $display("FAIL clear_idle busy=%b valid=%b want 0/0 (n=%0d)", busy, msgValid, n); end
        AuthorityContacted = 1'b0;
    endtask

    task automatic test_evac();
        logic need, clr;
        for (int k = 0; k < 40; k++) begin
            need = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 3) == 0);
            needEvacuation = need;
            allClear = clr;
            tick();
            total++; if (evacLight !== (need && !clr))
                begin bad++; $display("FAIL evac k=%0d got=%b want=%b", k, evacLight, need && !clr); end
        end
        needEvacuation = 1'b0;
        allClear = 1'b0;
        tick();
    endtask

    task automatic test_siren();
        int codes [3] = '{1, 2, 4};
        logic e;
        AuthorityContacted = 1'b0;
        for (int j = 0; j < 3; j++) begin
            setCode(codes[j]);
            warnStudents = 1'b1;
            for (int k = 0; k < 900; k++) begin
                tick();
                e = sirenModel(codes[j], k);
                total++; if (siren !== e)
                    begin bad++; $display("FAIL siren code=%0d k=%0d got=%b want=%b", codes[j], k, siren, e); end
            end
            warnStudents = 1'b0;
            tick();
            total++; if (siren !== 1'b0) begin bad++; $display("FAIL siren_off code=%0d got=%b want=0", codes[j], siren); end
            tick();
        end
        setCode(0);
    endtask

    task automatic test_reset_mid();
        int c, n;
        c = $urandom_range(1, 5);
        setCode(c);
        AuthorityContacted = 1'b1;
        warnStudents = 1'b1;
        needEvacuation = 1'b1;
        for (int k = 0; k < 1500; k++) tick();
        rst_n = 1'b0;
        tick();
        total++; if ({msgValid, msgCode, linkFault, siren, evacLight, busy} !== 8'd0)
            begin bad++; $display("FAIL midreset outs valid=%b code=%0d fault=%b siren=%b evac=%b busy=%b want all 0",
                                  msgValid, msgCode, linkFault, siren, evacLight, busy); end
        warnStudents = 1'b0;
        needEvacuation = 1'b0;
        rst_n = 1'b1;
        tick();
        total++; if (msgValid !== 1'b1 || busy !== 1'b1 || msgCode !== 3'(c))
            begin bad++; $display("FAIL midreset_fresh valid=%b busy=%b code=%0d want 1/1/%0d", msgValid, busy, msgCode, c); end
        n = 1;
        while (linkFault !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        total++; if (n != (MR + 1) * TO + MR + 1)
            begin bad++; $display("FAIL midreset_retry fault at cyc=%0d want=%0d", n, (MR + 1) * TO + MR + 1); end
        AuthorityContacted = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fire_ack();
        test_code_change();
        test_no_ack();
        test_clear();
        test_evac();
        test_siren();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
